rfid_poll_sequencer: RTL and testbench
======================================

Name: rfid_poll_sequencer

Overview:
- Sequences the 8-bit spi_master to poll the Arduino RFID bridge for a card UID.
- Each poll is five SPI byte transactions: command 0xAA, then four 0x00 dummy bytes. The replies to the dummy bytes are assembled into a 32-bit UID, MSB first.
- The UID is compared against two allow-listed UIDs to drive the authenticated flag consumed by the security_system state machine.
- Replaces the ad-hoc step counter in the top level; sits between the system FSM and spi_master.

Parameters:
- POLL_GAP, 28'd1000000, cycles idle between end of one poll and start of next (20 ms @ 50 MHz)
- CMD_UID, 8'hAA, command byte sent first in each poll
- UID_A, 32'h332C1EB7, allow-listed card UID 0
- UID_B, 32'h336BF410, allow-listed card UID 1
- ACK_TIMEOUT, 16'd64, max cycles from start pulse to spi_busy rising
- XFER_TIMEOUT, 28'd2000000, max cycles spi_busy may stay high for one byte

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; polling runs while high
- auth_clear  in  1  one-cycle pulse from system FSM on engage; clears authenticated
- spi_busy  in  1  busy_transaction from spi_master
- spi_rx  in  8  data_out from spi_master
- spi_start_n  out  1  active-low start to spi_master, one-cycle low pulse
- spi_tx  out  8  data_in to spi_master
- uid  out  32  last valid UID read
- uid_valid  out  1  one-cycle pulse when uid updates
- authenticated  out  1  level; set on allow-list match
- seq_err  out  1  one-cycle pulse on handshake timeout
- seq_active  out  1  high from LOAD of byte 0 until the poll ends (GAP/IDLE entered)

Behaviour:
- Reset values (async on reset high): state IDLE; spi_start_n=1; spi_tx=0; uid=0; uid_valid=0; authenticated=0; seq_err=0; seq_active=0; byte index=0; counters=0.
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, CAPTURE, COMPARE, GAP.
- IDLE: when enable=1, go to LOAD with byte index 0.
- LOAD: spi_tx <= CMD_UID for index 0, 8'h00 otherwise. Then go to START.
- START: spi_start_n=0 for exactly this cycle, only if spi_busy=0. If spi_busy=1, hold in START with spi_start_n=1. Then go to WAIT_ACK.
- WAIT_ACK: spi_busy=1 goes to WAIT_DONE. ACK_TIMEOUT cycles without it is an error.
- WAIT_DONE: spi_busy=0 goes to CAPTURE. XFER_TIMEOUT cycles in this state is an error.
- CAPTURE (1 cycle): index 0 reply is discarded. Index 1..4 writes spi_rx into shift register bits [39-8*idx : 32-8*idx], i.e. index 1 fills [31:24] and index 4 fills [7:0]. If index<4, increment index and go to LOAD; otherwise go to COMPARE.
- Per-byte latency: START to CAPTURE is ack delay + busy width + 2 cycles. spi_tx is stable from LOAD until CAPTURE.
- COMPARE (1 cycle):
  - Shift value 32'h00000000 or 32'hFFFFFFFF means no card: no uid_valid, uid unchanged.
  - Otherwise uid <= value and uid_valid pulses the next cycle.
  - If value equals UID_A or UID_B, authenticated <= 1. A non-matching UID does not clear authenticated.
  - Then go to GAP.
- Error: seq_err pulses one cycle, the shift register is discarded, state goes to GAP. uid and authenticated are unchanged.
- GAP: down-counter loads POLL_GAP-1 on entry. At 0: LOAD if enable, else IDLE. seq_active=0.
- enable falling mid-poll: the current byte runs to CAPTURE (spi_master cannot be aborted), then the block goes to IDLE. No COMPARE, no uid_valid.
- enable=0 in GAP: go to IDLE immediately.
- auth_clear: authenticated <= 0 in any state. If auth_clear and a COMPARE match occur in the same cycle, clear wins (authenticated=0).
- Reset mid-transaction: immediate return to IDLE, spi_start_n=1. spi_master is reset by the same top-level source.
- Counters saturate at no value; each is reloaded on state entry, so there is no wrap-around.

Test Plan:
Bench uses POLL_GAP=16, ACK_TIMEOUT=8, XFER_TIMEOUT=64. The spi_master model raises busy 2 cycles after the start pulse, holds it 10 cycles, and returns scripted bytes.
- Valid card: enable=1; replies xx,33,2C,1E,B7 -> spi_tx sequence AA,00,00,00,00; five spi_start_n pulses; uid=32'h332C1EB7; one uid_valid pulse; authenticated=1.
- Unknown card: replies xx,12,34,56,78 -> uid=32'h12345678, uid_valid pulses, authenticated stays 0. Next poll starts exactly 16 cycles after GAP entry.
- No card: replies all 00 and then all FF -> no uid_valid, uid keeps its prior value, authenticated unchanged.
- Timeout: model never raises busy on byte 2 -> seq_err pulses 8 cycles after the start pulse, then GAP, then a new poll starting with AA. Separately, busy stuck high -> seq_err after 64 cycles.
- Clear priority: pre-authenticated; auth_clear pulse coincides with a COMPARE of UID_B -> authenticated=0. A later poll of UID_B -> authenticated=1.
- Enable/reset mid-poll: drop enable during byte 2 busy -> byte completes, IDLE, no uid_valid. Assert reset during WAIT_DONE -> all outputs at reset values within the same cycle, spi_start_n=1.

Source files
------------

// File: rtl/rfid_poll_sequencer.sv
// Polls the Arduino RFID bridge through spi_master: one command byte plus four
// dummy bytes per poll, assembles the 32-bit UID and matches it against an allow-list.
module rfid_poll_sequencer #(
  parameter logic [27:0] POLL_GAP     = 28'd1000000,
  parameter logic [7:0]  CMD_UID      = 8'hAA,
  parameter logic [31:0] UID_A        = 32'h332C1EB7,
  parameter logic [31:0] UID_B        = 32'h336BF410,
  parameter logic [15:0] ACK_TIMEOUT  = 16'd64,
  parameter logic [27:0] XFER_TIMEOUT = 28'd2000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        auth_clear,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx,
  output logic        spi_start_n,
  output logic [7:0]  spi_tx,
  output logic [31:0] uid,
  output logic        uid_valid,
  output logic        authenticated,
  output logic        seq_err,
  output logic        seq_active
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_START     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_CAPTURE   = 3'd5,
    S_COMPARE   = 3'd6,
    S_GAP       = 3'd7
  } state_t;

  localparam logic [27:0] GAP_LOAD  = POLL_GAP - 28'd1;
  localparam logic [27:0] ACK_LOAD  = {12'd0, ACK_TIMEOUT} - 28'd1;
  localparam logic [27:0] XFER_LOAD = XFER_TIMEOUT - 28'd1;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [27:0] cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        err_s;
  logic        card_s;
  logic        match_s;

  logic        spi_start_n_q, spi_start_n_d;
  logic [7:0]  spi_tx_q, spi_tx_d;
  logic [31:0] uid_q, uid_d;
  logic        uid_valid_q, uid_valid_d;
  logic        auth_q, auth_d;
  logic        seq_err_q, seq_err_d;
  logic        seq_active_q, seq_active_d;

  // State, datapath and registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= 3'd0;
      cnt_q         <= 28'd0;
      shift_q       <= 32'd0;
      spi_start_n_q <= 1'b1;
      spi_tx_q      <= 8'd0;
      uid_q         <= 32'd0;
      uid_valid_q   <= 1'b0;
      auth_q        <= 1'b0;
      seq_err_q     <= 1'b0;
      seq_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      spi_start_n_q <= spi_start_n_d;
      spi_tx_q      <= spi_tx_d;
      uid_q         <= uid_d;
      uid_valid_q   <= uid_valid_d;
      auth_q        <= auth_d;
      seq_err_q     <= seq_err_d;
      seq_active_q  <= seq_active_d;
    end
  end

  // Next-state, byte index, timeout counter and UID shift register
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    err_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD;
          idx_d   = 3'd0;
          shift_d = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_START;
      end
      S_START: begin
        if (!spi_busy) begin
          state_d = S_WAIT_ACK;
          cnt_d   = ACK_LOAD;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT_ACK: begin
        if (spi_busy) begin
          state_d = S_WAIT_DONE;
          cnt_d   = XFER_LOAD;
        end else if (cnt_q == 28'd0) begin
          err_s   = 1'b1;
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          shift_d = 32'd0;
        end else begin
          cnt_d = cnt_q - 28'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == 28'd0) begin
          err_s   = 1'b1;
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
          shift_d = 32'd0;
        end else begin
          cnt_d = cnt_q - 28'd1;
        end
      end
      S_CAPTURE: begin
        // The reply clocked out with the command byte carries no UID data.
        case (idx_q)
          3'd1:    shift_d[31:24] = spi_rx;
          3'd2:    shift_d[23:16] = spi_rx;
          3'd3:    shift_d[15:8]  = spi_rx;
          3'd4:    shift_d[7:0]   = spi_rx;
          default: shift_d        = shift_q;
        endcase
        if (!enable) begin
          state_d = S_IDLE;
        end else if (idx_q < 3'd4) begin
          state_d = S_LOAD;
          idx_d   = idx_q + 3'd1;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        state_d = S_GAP;
        cnt_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == 28'd0) begin
          state_d = S_LOAD;
          idx_d   = 3'd0;
          shift_d = 32'd0;
        end else begin
          cnt_d = cnt_q - 28'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values registered on the next edge
  always_comb begin
    card_s  = (shift_q != 32'h0000_0000) && (shift_q != 32'hFFFF_FFFF);
    match_s = (shift_q == UID_A) || (shift_q == UID_B);

    if ((state_q == S_START) && !spi_busy) begin
      spi_start_n_d = 1'b0;
    end else begin
      spi_start_n_d = 1'b1;
    end

    if (state_d == S_LOAD) begin
      if (idx_d == 3'd0) begin
        spi_tx_d = CMD_UID;
      end else begin
        spi_tx_d = 8'h00;
      end
    end else begin
      spi_tx_d = spi_tx_q;
    end

    if ((state_q == S_COMPARE) && card_s) begin
      uid_d       = shift_q;
      uid_valid_d = 1'b1;
    end else begin
      uid_d       = uid_q;
      uid_valid_d = 1'b0;
    end

    // Clearing from the system FSM outranks a simultaneous match.
    if (auth_clear) begin
      auth_d = 1'b0;
    end else if ((state_q == S_COMPARE) && match_s) begin
      auth_d = 1'b1;
    end else begin
      auth_d = auth_q;
    end

    seq_err_d = err_s;

    case (state_d)
      S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE, S_CAPTURE, S_COMPARE: seq_active_d = 1'b1;
      default:                                                       seq_active_d = 1'b0;
    endcase
  end

  assign spi_start_n   = spi_start_n_q;
  assign spi_tx        = spi_tx_q;
  assign uid           = uid_q;
  assign uid_valid     = uid_valid_q;
  assign authenticated = auth_q;
  assign seq_err       = seq_err_q;
  assign seq_active    = seq_active_q;

endmodule

// File: tb/tb_rfid_poll_sequencer.sv
// Scoreboard bench for rfid_poll_sequencer with a scripted spi_master model
// (busy rises 2 cycles after the start pulse and stays high 10 cycles).
module tb_rfid_poll_sequencer;

  localparam int NOBUSY = 256;
  localparam int STUCK  = 257;
  localparam logic [31:0] UIDA = 32'h332C1EB7;
  localparam logic [31:0] UIDB = 32'h336BF410;

  logic        clk = 1'b0;
  logic        rst, enable, auth_clear, spi_busy;
  logic [7:0]  spi_rx;
  logic        spi_start_n, uid_valid, authenticated, seq_err, seq_active;
  logic [7:0]  spi_tx;
  logic [31:0] uid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int mdl_r, mdl_hold;
  int n;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_uid[$];
  int          exp_err[$];
  int          replies[$];

  rfid_poll_sequencer #(
    .POLL_GAP(28'd16), .ACK_TIMEOUT(16'd8), .XFER_TIMEOUT(28'd64)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .enable(enable), .auth_clear(auth_clear),
    .spi_busy(spi_busy), .spi_rx(spi_rx), .spi_start_n(spi_start_n), .spi_tx(spi_tx),
    .uid(uid), .uid_valid(uid_valid), .authenticated(authenticated),
    .seq_err(seq_err), .seq_active(seq_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected pulse, expected none", nm);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; auth_clear = 1'b0;
    exp_tx.delete(); exp_uid.delete(); exp_err.delete(); replies.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  // Script one five-byte poll: reply bytes and the spi_tx the DUT must send.
  task automatic push_poll(input logic [31:0] v);
    replies.push_back(32'h5A);
    replies.push_back(int'(v[31:24])); replies.push_back(int'(v[23:16]));
    replies.push_back(int'(v[15:8]));  replies.push_back(int'(v[7:0]));
    exp_tx.push_back(8'hAA);
    repeat (4) exp_tx.push_back(8'h00);
  endtask

  task automatic wait_uid(input string nm);
    int k = 0;
    do begin tick(); k++; end while (!uid_valid && k < 400);
    check(nm, uid_valid, 1'b1);
  endtask

  task automatic wait_err(input string nm);
    int k = 0;
    do begin tick(); k++; end while (!seq_err && k < 400);
    check(nm, seq_err, 1'b1);
  endtask

  task automatic wait_starts(input string nm, input int cnt);
    int seen = 0;
    int k = 0;
    while (seen < cnt && k < 2000) begin
      tick(); k++;
      if (!spi_start_n) seen++;
    end
    check(nm, seen, cnt);
  endtask

  task automatic wait_inactive(input string nm, output int k);
    k = 0;
    do begin tick(); k++; end while ((seq_active || spi_busy) && k < 300);
    check(nm, {31'd0, seq_active | spi_busy}, 32'd0);
  endtask

  task automatic check_drained(input string nm);
    check({nm, "_tx_left"}, exp_tx.size(), 0);
    check({nm, "_uid_left"}, exp_uid.size(), 0);
    check({nm, "_err_left"}, exp_err.size(), 0);
  endtask

  // spi_master model: replies come from the script; reset aborts a transfer.
  initial begin
    spi_busy = 1'b0;
    spi_rx   = 8'h00;
    forever begin
      tick();
      if (!rst && !spi_start_n) begin
        mdl_r = (replies.size() > 0) ? replies.pop_front() : 0;
        if (mdl_r != NOBUSY) begin
          mdl_hold = (mdl_r == STUCK) ? 80 : 10;
          for (int i = 0; i < 2 && !rst; i++) tick();
          if (!rst) begin
            spi_busy = 1'b1;
            for (int i = 0; i < mdl_hold && !rst; i++) tick();
          end
          spi_busy = 1'b0;
          if (mdl_r < 256) spi_rx = mdl_r[7:0];
        end
      end
    end
  end

  // Monitor: every start pulse, uid_valid and seq_err is matched against the queues.
  initial begin
    forever begin
      tick();
      cyc++;
      if (!rst) begin
        if (!spi_start_n) begin
          last_start_cyc = cyc;
          if (exp_tx.size() == 0) unexpected("start_pulse");
          else check("spi_tx", spi_tx, exp_tx.pop_front());
        end
        if (uid_valid) begin
          if (exp_uid.size() == 0) unexpected("uid_valid");
          else check("uid", uid, exp_uid.pop_front());
        end
        if (seq_err) begin
          if (exp_err.size() == 0) unexpected("seq_err");
          else check("err_delay", cyc - last_start_cyc, exp_err.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; auth_clear = 1'b0;
    do_reset();
    check("rst_start_n", spi_start_n, 1'b1);
    check("rst_tx", spi_tx, 8'h00);
    check("rst_uid", uid, 32'd0);
    check("rst_flags", {uid_valid, authenticated, seq_err, seq_active}, 4'b0000);

    // Valid card: UID_A sets authenticated.
    push_poll(UIDA); exp_uid.push_back(UIDA);
    enable = 1'b1;
    wait_uid("valid_uid_seen");
    enable = 1'b0;
    check("valid_auth", authenticated, 1'b1);
    check("valid_active_low", seq_active, 1'b0);
    repeat (5) tick();
    check_drained("valid");

    // Unknown card: uid updates, no auth; next poll 16 cycles after GAP entry.
    do_reset();
    push_poll(32'h12345678); exp_uid.push_back(32'h12345678);
    replies.push_back(32'h5A); exp_tx.push_back(8'hAA);
    enable = 1'b1;
    wait_uid("unknown_uid_seen");
    check("unknown_auth", authenticated, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!seq_active && n < 100);
    check("gap_length", n, 16);
    enable = 1'b0;
    wait_inactive("unknown_stop", n);
    check_drained("unknown");

    // No card: all-zero and all-ones polls leave uid/auth alone.
    do_reset();
    push_poll(UIDA); exp_uid.push_back(UIDA);
    push_poll(32'h00000000);
    push_poll(32'hFFFFFFFF);
    enable = 1'b1;
    n = 0;
    while (exp_tx.size() > 0 && n < 2000) begin tick(); n++; end
    n = 0;
    while (seq_active && n < 100) begin tick(); n++; end
    enable = 1'b0;
    repeat (3) tick();
    check("nocard_uid", uid, UIDA);
    check("nocard_auth", authenticated, 1'b1);
    check_drained("nocard");

    // Ack timeout on byte 2, then a fresh poll beginning with AA.
    do_reset();
    replies.push_back(32'h5A); replies.push_back(32'h33); replies.push_back(NOBUSY);
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    exp_err.push_back(8);
    push_poll(UIDA); exp_uid.push_back(UIDA);
    enable = 1'b1;
    wait_err("ack_err_seen");
    check("ack_err_gap", seq_active, 1'b0);
    check("ack_err_uid", uid, 32'd0);
    wait_uid("ack_retry_uid");
    enable = 1'b0;
    repeat (3) tick();
    check_drained("ack");

    // Busy stuck high on byte 1: 2-cycle ack, WAIT_DONE entered one cycle later, 64 cycles there.
    do_reset();
    replies.push_back(32'h5A); replies.push_back(STUCK);
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'h00);
    exp_err.push_back(2 + 1 + 64);
    enable = 1'b1;
    wait_err("xfer_err_seen");
    enable = 1'b0;
    check("xfer_err_gap", seq_active, 1'b0);
    wait_inactive("xfer_stop", n);
    check_drained("xfer");

    // auth_clear in the COMPARE cycle of a UID_B poll wins; a later UID_B poll re-authenticates.
    do_reset();
    push_poll(UIDA); exp_uid.push_back(UIDA);
    push_poll(UIDB); exp_uid.push_back(UIDB);
    enable = 1'b1;
    wait_starts("clr_byte4_start", 10);
    check("clr_pre_auth", authenticated, 1'b1);
    push_poll(UIDB); exp_uid.push_back(UIDB);
    repeat (14) tick();
    auth_clear = 1'b1;
    tick();
    auth_clear = 1'b0;
    check("clr_uid_valid", uid_valid, 1'b1);
    check("clr_uid", uid, UIDB);
    check("clr_auth", authenticated, 1'b0);
    wait_uid("clr_repoll_uid");
    enable = 1'b0;
    check("clr_reauth", authenticated, 1'b1);
    repeat (3) tick();
    check_drained("clr");

    // enable dropped during byte 2 busy: byte finishes, IDLE 9 cycles later, no uid_valid.
    do_reset();
    push_poll(UIDA);
    repeat (2) void'(exp_tx.pop_back());
    enable = 1'b1;
    wait_starts("endrop_start", 3);
    repeat (5) tick();
    enable = 1'b0;
    wait_inactive("endrop_stop", n);
    check("endrop_latency", n, 9);
    repeat (20) tick();
    check("endrop_uid", uid, 32'd0);
    check_drained("endrop");

    // Reset during WAIT_DONE of a second poll.
    do_reset();
    push_poll(UIDA); exp_uid.push_back(UIDA);
    replies.push_back(32'h5A); exp_tx.push_back(8'hAA);
    enable = 1'b1;
    wait_uid("rstmid_uid");
    wait_starts("rstmid_start", 1);
    repeat (4) tick();
    check("rstmid_tx_left", exp_tx.size(), 0);
    rst = 1'b1;
    #1;
    check("rstmid_start_n", spi_start_n, 1'b1);
    check("rstmid_tx", spi_tx, 8'h00);
    check("rstmid_uid", uid, 32'd0);
    check("rstmid_flags", {uid_valid, authenticated, seq_err, seq_active}, 4'b0000);
    enable = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
